pipe_stall_ctrl: RTL

//  Pipeline-register control downstream of hazard detection. Turns load-use stall requests,
//  EX-stage branch redirects, data-memory busy and WB-stage HALT into per-stage write

---
 rtl/pipe_stall_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: pipeline-register control downstream of hazard detection.
// Turns load-use stalls, EX-stage branch redirects, data-memory busy and
// WB-stage HALT into per-stage write enables and flush/bubble strobes.
// Optional feature macro: STALL_PERF_CNT_EN builds the stall/flush performance
// counters; without it both counter outputs are tied to zero.
module pipe_stall_ctrl #(
    parameter int LD_STALL_CYC = 1,   // freeze cycles per load-use request (1..7)
    parameter int CNT_W        = 16   // performance counter width
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_use_stall,
    input  logic             branch_taken,
    input  logic             dmem_stall,
    input  logic             halt_wb,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_flush,
    output logic             exmem_we,
    output logic             exmem_bubble,
    output logic             memwb_we,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, LDSTALL, MEMWAIT, HALT} stateE;

    stateE      state, nextState;
    logic [2:0] ldCnt, nextLdCnt;
    logic       flushPend, nextFlushPend;
    // Write enables packed as {pc, ifid, idex, exmem, memwb}.
    logic [4:0] weVec;

    assign {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = weVec;

    // Output decode and next-state logic; outputs react to inputs in the same cycle.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        nextState     = state;
        nextLdCnt     = ldCnt;
        nextFlushPend = flushPend;
        weVec         = 5'b11111;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        exmem_bubble  = 1'b0;
        halted        = 1'b0;

        if (!rst_n) begin
            // Pipe is held empty while reset is asserted.
            weVec        = 5'b00000;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            exmem_bubble = 1'b1;
        end else if (state == HALT) begin
            weVec  = 5'b00000;
            halted = 1'b1;
        end else if (halt_wb) begin
            weVec     = 5'b00000;
            nextState = HALT;
        end else if (dmem_stall) begin
            // Full freeze; a load-use countdown simply holds its place.
            weVec = 5'b00000;
            if (state != LDSTALL) begin
                nextState = MEMWAIT;
                // The redirect cannot be applied while frozen; remember it.
                if (branch_taken) nextFlushPend = 1'b1;
            end
        end else if (state == LDSTALL) begin
            // Keep the consumer in ID/EX, inject a bubble into EX/MEM.
            weVec        = 5'b00011;
            exmem_bubble = 1'b1;
            nextLdCnt    = ldCnt - 3'd1;
            if (ldCnt == 3'd1) nextState = RUN;
        end else begin
            // RUN, or the first unfrozen cycle after MEMWAIT.
            nextState = RUN;
            if (flushPend) begin
                ifid_flush    = 1'b1;
                idex_flush    = 1'b1;
                nextFlushPend = 1'b0;
            end
            if (ld_use_stall) begin
                // Branch outcome is based on stale operands this cycle, so it is ignored.
                weVec        = 5'b00011;
                exmem_bubble = 1'b1;
                if (LD_STALL_CYC > 1) begin
                    nextState = LDSTALL;
                    nextLdCnt = 3'(LD_STALL_CYC - 1);
                end
            end else if (branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end
        end
    end

    // FSM state, load-use countdown and deferred-flush flag.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state     <= RUN;
            ldCnt     <= 3'd0;
            flushPend <= 1'b0;
        end else begin
            state     <= nextState;
            ldCnt     <= nextLdCnt;
            flushPend <= nextFlushPend;
        end
    end

`ifdef STALL_PERF_CNT_EN
    // Saturating counters: frozen-PC cycles outside HALT, and cycles a flush is applied.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (state != HALT && !pc_we && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (ifid_flush && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
